// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 MAR/MDR/RAM access sequencer.
package lc3_mem_pkg;

  localparam int DATA_W      = 16;
  localparam int RD_WAIT_MAX = 7;
  localparam int CNT_W       = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_MAR = 3'd1,
    LD_WD  = 3'd2,
    WRITE  = 3'd3,
    WAIT   = 3'd4,
    LD_RD  = 3'd5,
    RESP   = 3'd6
  } state_e;

endpackage

// File: rtl/bit_16_reg.sv
// Load-enabled data register with asynchronous clear; holds one request field.
module bit_16_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = en ? d : q_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one LC-3 memory read or write through MAR/MDR/RAM per request and
// returns a single-cycle response; the only source of memWE in the system.
module mem_access_ctrl #(
  parameter int DATA_W  = lc3_mem_pkg::DATA_W,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic [DATA_W-1:0] mdr_q,
  output logic [DATA_W-1:0] bus_drv,
  output logic              bus_en,
  output logic              ldMAR,
  output logic              ldMDR,
  output logic              selMDR,
  output logic              memWE
);
  import lc3_mem_pkg::*;

  if (RD_WAIT < 0 || RD_WAIT > RD_WAIT_MAX) begin : g_bad_rd_wait
    $error("mem_access_ctrl: RD_WAIT must be in 0..7");
  end

  // WAIT lasts RD_WAIT cycles, so the counter starts one below and exits at zero
  localparam logic [CNT_W-1:0] WAIT_LOAD = (RD_WAIT > 0) ? CNT_W'(RD_WAIT - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, data_q;
  logic              accept;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  bit_16_reg #(.W(DATA_W)) u_addr_reg (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .d     (req_addr),
    .q     (addr_q)
  );

  bit_16_reg #(.W(DATA_W)) u_data_reg (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .d     (req_data),
    .q     (data_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          state_d = LD_MAR;
        end
      end
      LD_MAR: begin
        cnt_d = WAIT_LOAD;
        if (we_q)             state_d = LD_WD;
        else if (RD_WAIT > 0) state_d = WAIT;
        else                  state_d = LD_RD;
      end
      LD_WD:  state_d = WRITE;
      WRITE:  state_d = RESP;
      WAIT: begin
        if (cnt_q == '0) state_d = LD_RD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      LD_RD:  state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  // Pure state decode: reset clears every strobe in the same instant
  always_comb begin
    bus_drv   = '0;
    bus_en    = 1'b0;
    ldMAR     = 1'b0;
    ldMDR     = 1'b0;
    selMDR    = 1'b0;
    memWE     = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    case (state_q)
      LD_MAR: begin
        bus_en  = 1'b1;
        bus_drv = addr_q;
        ldMAR   = 1'b1;
      end
      LD_WD: begin
        bus_en  = 1'b1;
        bus_drv = data_q;
        ldMDR   = 1'b1;
      end
      WRITE: memWE = 1'b1;
      LD_RD: begin
        selMDR = 1'b1;
        ldMDR  = 1'b1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = we_q ? '0 : mdr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Drives three controller builds (RD_WAIT = 1, 0, 3) against a MAR/MDR/RAM model
// and compares timing and data with a transaction-level memory reference.
module tb_mem_access_ctrl;

  localparam int NI = 3;
  localparam int RW_TAB [NI] = '{1, 0, 3};

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [NI];
  logic        req_we    [NI];
  logic [15:0] req_addr  [NI];
  logic [15:0] req_data  [NI];
  logic        req_ready [NI];
  logic        rsp_valid [NI];
  logic [15:0] rsp_data  [NI];
  logic [15:0] mdr_q     [NI];
  logic [15:0] bus_drv   [NI];
  logic        bus_en    [NI];
  logic        ldMAR     [NI];
  logic        ldMDR     [NI];
  logic        selMDR    [NI];
  logic        memWE     [NI];

  int total = 0;
  int bad   = 0;

  // Expected memory contents, keyed by instance*65536 + address
  logic [15:0] ref_mem [int];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int RW = RW_TAB[g];
    logic [15:0] mar, mdr, ram_rd, ram_out, bus;
    logic [15:0] ram  [0:65535];
    logic [15:0] pipe [0:7];

    // Environment: MAR, MDR and a RAM whose output lags MAR by RW cycles
    assign bus    = bus_en[g] ? bus_drv[g] : 16'h0000;
    assign ram_rd = ram[mar];
    always @(posedge clk) begin
      if (ldMAR[g]) mar <= bus;
      if (ldMDR[g]) mdr <= selMDR[g] ? ram_out : bus;
      if (memWE[g]) ram[mar] <= mdr;
      pipe[0] <= ram_rd;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    if (RW == 0) begin : g_async
      assign ram_out = ram_rd;
    end else begin : g_sync
      assign ram_out = pipe[RW-1];
    end
    assign mdr_q[g] = mdr;

    mem_access_ctrl #(.DATA_W(16), .RD_WAIT(RW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_data  (req_data[g]),
      .req_ready (req_ready[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_data  (rsp_data[g]),
      .mdr_q     (mdr_q[g]),
      .bus_drv   (bus_drv[g]),
      .bus_en    (bus_en[g]),
      .ldMAR     (ldMAR[g]),
      .ldMDR     (ldMDR[g]),
      .selMDR    (selMDR[g]),
      .memWE     (memWE[g])
    );
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input int k);
    check_output("rst_req_ready", {31'd0, req_ready[k]}, 32'd1);
    check_output("rst_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
    check_output("rst_memWE",     {31'd0, memWE[k]},     32'd0);
    check_output("rst_ldMAR",     {31'd0, ldMAR[k]},     32'd0);
    check_output("rst_ldMDR",     {31'd0, ldMDR[k]},     32'd0);
    check_output("rst_selMDR",    {31'd0, selMDR[k]},    32'd0);
    check_output("rst_bus_en",    {31'd0, bus_en[k]},    32'd0);
    check_output("rst_bus_drv",   {16'd0, bus_drv[k]},   32'd0);
    check_output("rst_rsp_data",  {16'd0, rsp_data[k]},  32'd0);
  endtask

  task automatic wait_ready(input int k);
    int waited;
    waited = 0;
    while (req_ready[k] !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check_output("ready_timeout", {31'd0, waited < 20}, 32'd1);
  endtask

  // One complete request with per-cycle observation, checked against the spec timing
  task automatic apply_stimulus(input int k, input logic we, input logic [15:0] addr, input logic [15:0] data);
    int mar_cyc, mdr_cyc, we_cyc, we_cnt, rsp_cyc, rsp_cnt, both_cnt, ready_hi;
    int rw, key;
    logic [15:0] mar_val, mdr_bus, got, exp_rd;
    logic mdr_sel;
    rw = RW_TAB[k];
    key = k * 65536 + int'(addr);
    mar_cyc = -1; mdr_cyc = -1; we_cyc = -1; rsp_cyc = -1;
    we_cnt = 0; rsp_cnt = 0; both_cnt = 0; ready_hi = 0;
    mar_val = 16'h0; mdr_bus = 16'h0; got = 16'h0; mdr_sel = 1'b0;
    wait_ready(k);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_data[k] = data;
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_we[k] = ~we;
    req_addr[k] = 16'($urandom); req_data[k] = 16'($urandom);
    for (int c = 1; c <= 14; c++) begin
      if (ldMAR[k]) begin mar_cyc = c; mar_val = bus_en[k] ? bus_drv[k] : 16'h0; end
      if (ldMDR[k]) begin mdr_cyc = c; mdr_sel = selMDR[k]; mdr_bus = bus_en[k] ? bus_drv[k] : 16'h0; end
      if (memWE[k]) begin we_cyc = c; we_cnt++; end
      if (ldMAR[k] && ldMDR[k]) both_cnt++;
      if (req_ready[k]) ready_hi++;
      if (rsp_valid[k]) begin rsp_cyc = c; got = rsp_data[k]; rsp_cnt++; end
      if (rsp_cnt > 0) break;
      @(posedge clk); #1;
    end
    check_output("rsp_count",   rsp_cnt, 1);
    check_output("rsp_latency", rsp_cyc, we ? 4 : 3 + rw);
    check_output("ldMAR_cycle", mar_cyc, 1);
    check_output("ldMAR_bus",   {16'd0, mar_val}, {16'd0, addr});
    check_output("ldMDR_cycle", mdr_cyc, we ? 2 : 2 + rw);
    check_output("selMDR",      {31'd0, mdr_sel}, {31'd0, ~we});
    check_output("memWE_count", we_cnt, we ? 1 : 0);
    check_output("ld_overlap",  both_cnt, 0);
    check_output("ready_busy",  ready_hi, 0);
    if (we) begin
      check_output("memWE_cycle", we_cyc, 3);
      check_output("ldMDR_bus",   {16'd0, mdr_bus}, {16'd0, data});
      check_output("wr_rsp_data", {16'd0, got}, 32'd0);
      ref_mem[key] = data;
    end else begin
      exp_rd = ref_mem.exists(key) ? ref_mem[key] : 16'h0;
      check_output("rd_rsp_data", {16'd0, got}, {16'd0, exp_rd});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int b2b_mar [$];
    int b2b_rsp [$];
    logic [15:0] b2b_data [$];
    int ready_lo_first, cnt_we, cnt_rsp;
    logic [15:0] wq [$];
    logic we;
    logic [15:0] a, d;

    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 16'h0; req_data[k] = 16'h0;
    end
    #12;
    for (int k = 0; k < NI; k++) check_idle_outputs(k);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Directed write then read back on every build
    for (int k = 0; k < NI; k++) begin
      apply_stimulus(k, 1'b1, 16'h3000, 16'hBEEF);
      apply_stimulus(k, 1'b0, 16'h3000, 16'h0000);
    end

    // Back-to-back: req_valid stays high across a write followed by a read
    wait_ready(0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h5000; req_data[0] = 16'hA5A5;
    @(posedge clk); #1;
    req_we[0] = 1'b0; req_data[0] = 16'h1111;
    ready_lo_first = 0;
    for (int c = 1; c <= 14; c++) begin
      if (ldMAR[0]) begin
        b2b_mar.push_back(c);
        if (c > 1) req_valid[0] = 1'b0;
      end
      if (c <= 4 && req_ready[0]) ready_lo_first++;
      if (rsp_valid[0]) begin b2b_rsp.push_back(c); b2b_data.push_back(rsp_data[0]); end
      if (b2b_rsp.size() == 2) break;
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    ref_mem[16'h5000] = 16'hA5A5;
    check_output("b2b_ready_low", ready_lo_first, 0);
    check_output("b2b_accepts",   b2b_mar.size(), 2);
    check_output("b2b_rsps",      b2b_rsp.size(), 2);
    if (b2b_mar.size() == 2) check_output("b2b_second_mar", b2b_mar[1], 6);
    if (b2b_rsp.size() == 2) begin
      check_output("b2b_rsp1_cycle", b2b_rsp[0], 4);
      check_output("b2b_rsp2_cycle", b2b_rsp[1], 9);
      check_output("b2b_rd_data",    {16'd0, b2b_data[1]}, 32'h0000A5A5);
    end

    // Reset while the write is in LD_WD: the write must never reach RAM
    apply_stimulus(0, 1'b1, 16'h4000, 16'h1234);
    wait_ready(0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h4000; req_data[0] = 16'hDEAD;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    check_output("ldwd_ldMDR", {31'd0, ldMDR[0]}, 32'd1);
    #2 reset = 1'b1;
    #1 check_idle_outputs(0);
    cnt_we = 0; cnt_rsp = 0;
    @(posedge clk); #3 reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (memWE[0]) cnt_we++;
      if (rsp_valid[0]) cnt_rsp++;
    end
    check_output("rst_no_memWE", cnt_we, 0);
    check_output("rst_no_rsp",   cnt_rsp, 0);
    apply_stimulus(0, 1'b0, 16'h4000, 16'h0000);

    // Randomized traffic per build; reads target addresses already written
    for (int k = 0; k < NI; k++) begin
      wq.delete();
      wq.push_back(16'h3000);
      for (int n = 0; n < 25; n++) begin
        we = ($urandom_range(0, 1) == 1) || (n == 0);
        if (we) begin
          case ($urandom_range(0, 5))
            0:       a = 16'h0000;
            1:       a = 16'hFFFF;
            default: a = 16'($urandom);
          endcase
          case ($urandom_range(0, 5))
            0:       d = 16'h0000;
            1:       d = 16'hFFFF;
            default: d = 16'($urandom);
          endcase
          wq.push_back(a);
        end else begin
          a = wq[$urandom_range(0, wq.size() - 1)];
          d = 16'($urandom);
        end
        apply_stimulus(k, we, a, d);
      end
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
